// File: rtl/mem_arbiter_rr_pkg.sv
// rtl/mem_arbiter_rr_pkg.sv - shared types and helpers for the memory-port arbiter
package mem_arbiter_rr_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANT   = 2'd1,
        ARB_RELEASE = 2'd2
    } arb_state_t;

    localparam int DEF_N_CH   = 3;
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_DATA_W = 128;

    // Index width that stays at least one bit wide for degenerate counts.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_arbiter_rr_if.sv
// rtl/mem_arbiter_rr_if.sv - requester/memory bundle seen by the arbiter
interface mem_arbiter_rr_if
    import mem_arbiter_rr_pkg::*;
#(
    parameter int N_CH   = DEF_N_CH,
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic [N_CH-1:0]        ch_req;
    logic [N_CH-1:0]        ch_rw;
    logic [N_CH*ADDR_W-1:0] ch_addr;
    logic [N_CH*DATA_W-1:0] ch_wdata;
    logic [N_CH-1:0]        ch_ack;
    logic [DATA_W-1:0]      ch_rdata;
    logic                   mem_enable;
    logic                   mem_rw;
    logic [ADDR_W-1:0]      mem_addr;
    logic [DATA_W-1:0]      mem_data_in;
    logic [DATA_W-1:0]      mem_data_out;
    logic                   mem_ack;

    // master: the arbiter itself; slave: the caches plus the memory pins
    modport master (
        input  ch_req, ch_rw, ch_addr, ch_wdata, mem_data_out, mem_ack,
        output ch_ack, ch_rdata, mem_enable, mem_rw, mem_addr, mem_data_in
    );

    modport slave (
        output ch_req, ch_rw, ch_addr, ch_wdata, mem_data_out, mem_ack,
        input  ch_ack, ch_rdata, mem_enable, mem_rw, mem_addr, mem_data_in
    );

endinterface

// File: rtl/mem_arbiter_rr_rr_priority_select.sv
// rtl/mem_arbiter_rr_rr_priority_select.sv - combinational winner pick, rotating or fixed
module rr_priority_select #(
    parameter int N_CH  = 3,
    parameter int IDX_W = 2
) (
    input  logic [N_CH-1:0]  req,
    input  logic [IDX_W-1:0] ptr,
    input  logic             rr_mode,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_valid
);

    localparam logic [IDX_W:0] N_CH_W = (IDX_W+1)'(N_CH);

    logic [IDX_W-1:0] start;
    logic [IDX_W:0]   cand;

    // Walk from the farthest candidate back to the start so the closest one wins.
    always_comb begin
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        cand      = '0;
        start     = rr_mode ? ptr : '0;
        for (int k = N_CH - 1; k >= 0; k--) begin
            cand = {1'b0, start} + (IDX_W+1)'(k);
            if (cand >= N_CH_W) begin
                cand = cand - N_CH_W;
            end
            if (req[cand[IDX_W-1:0]]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/mem_arbiter_rr.sv
// rtl/mem_arbiter_rr.sv - N-channel cache-to-memory arbiter with ack timeout monitor
module mem_arbiter_rr
    import mem_arbiter_rr_pkg::*;
#(
    parameter int   N_CH    = DEF_N_CH,
    parameter int   ADDR_W  = DEF_ADDR_W,
    parameter int   DATA_W  = DEF_DATA_W,
    parameter bit   RR_MODE = 1'b1,
    parameter int   TIMEOUT = 255,
    localparam int  IDX_W   = idx_w(N_CH)
) (
    input  logic             clk,
    input  logic             reset,
    mem_arbiter_rr_if.master bus,
    output logic [IDX_W-1:0] grant_id,
    output logic             busy,
    output logic             timeout_err
);

    localparam int               CNT_W    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] TO_MAX   = CNT_W'(TIMEOUT);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CH - 1);

    arb_state_t       state, state_nxt;
    logic [IDX_W-1:0] ptr;
    logic [IDX_W-1:0] gnt_idx;
    logic             gnt_valid;
    logic             grant_load;
    logic             complete;
    logic [CNT_W-1:0] to_cnt;

    logic [ADDR_W-1:0] addr_arr  [N_CH];
    logic [DATA_W-1:0] wdata_arr [N_CH];

    for (genvar g = 0; g < N_CH; g++) begin : g_unpack
        assign addr_arr[g]  = bus.ch_addr[g*ADDR_W +: ADDR_W];
        assign wdata_arr[g] = bus.ch_wdata[g*DATA_W +: DATA_W];
    end

    rr_priority_select #(
        .N_CH  (N_CH),
        .IDX_W (IDX_W)
    ) u_sel (
        .req       (bus.ch_req),
        .ptr       (ptr),
        .rr_mode   (RR_MODE),
        .gnt_idx   (gnt_idx),
        .gnt_valid (gnt_valid)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ARB_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Requests are only looked at in IDLE; RELEASE gives requesters a cycle to drop.
    always_comb begin
        state_nxt  = state;
        grant_load = 1'b0;
        complete   = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (gnt_valid) begin
                    state_nxt  = ARB_GRANT;
                    grant_load = 1'b1;
                end
            end
            ARB_GRANT: begin
                if (bus.mem_ack) begin
                    state_nxt = ARB_RELEASE;
                    complete  = 1'b1;
                end
            end
            ARB_RELEASE: state_nxt = ARB_IDLE;
            default:     state_nxt = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr             <= '0;
            grant_id        <= '0;
            busy            <= 1'b0;
            timeout_err     <= 1'b0;
            to_cnt          <= '0;
            bus.mem_enable  <= 1'b0;
            bus.mem_rw      <= 1'b0;
            bus.mem_addr    <= '0;
            bus.mem_data_in <= '0;
            bus.ch_ack      <= '0;
            bus.ch_rdata    <= '0;
        end else begin
            busy       <= (state_nxt != ARB_IDLE);
            bus.ch_ack <= '0;

            if (grant_load) begin
                grant_id        <= gnt_idx;
                bus.mem_enable  <= 1'b1;
                bus.mem_rw      <= bus.ch_rw[gnt_idx];
                bus.mem_addr    <= addr_arr[gnt_idx];
                bus.mem_data_in <= wdata_arr[gnt_idx];
                to_cnt          <= '0;
            end

            // Timeout only flags; the transaction keeps waiting for its ack.
            if (TIMEOUT > 0 && state == ARB_GRANT && !bus.mem_ack && to_cnt != TO_MAX) begin
                to_cnt <= to_cnt + CNT_W'(1);
                if (to_cnt == TO_MAX - CNT_W'(1)) begin
                    timeout_err <= 1'b1;
                end
            end

            if (complete) begin
                bus.mem_enable       <= 1'b0;
                bus.ch_ack[grant_id] <= 1'b1;
                if (!bus.mem_rw) begin
                    bus.ch_rdata <= bus.mem_data_out;
                end
                ptr <= (grant_id == LAST_IDX) ? '0 : grant_id + IDX_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter_rr.sv
// tb/tb_mem_arbiter_rr.sv - self-checking bench for mem_arbiter_rr (round-robin and fixed)
module tb_mem_arbiter_rr;

    localparam int N  = 3;
    localparam int AW = 32;
    localparam int DW = 128;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    mem_arbiter_rr_if #(.N_CH(N), .ADDR_W(AW), .DATA_W(DW)) if_rr ();
    mem_arbiter_rr_if #(.N_CH(N), .ADDR_W(AW), .DATA_W(DW)) if_fx ();

    logic [1:0] gid_rr, gid_fx;
    logic       busy_rr, busy_fx;
    logic       to_rr, to_fx;

    mem_arbiter_rr #(.N_CH(N), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(1'b1), .TIMEOUT(8)) dut_rr (
        .clk(clk), .reset(reset), .bus(if_rr.master),
        .grant_id(gid_rr), .busy(busy_rr), .timeout_err(to_rr)
    );

    mem_arbiter_rr #(.N_CH(N), .ADDR_W(AW), .DATA_W(DW), .RR_MODE(1'b0), .TIMEOUT(255)) dut_fx (
        .clk(clk), .reset(reset), .bus(if_fx.master),
        .grant_id(gid_fx), .busy(busy_fx), .timeout_err(to_fx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Requester-side state of the round-robin instance
    logic [N-1:0]  req;
    logic          p_rw   [N];
    logic [AW-1:0] p_addr [N];
    logic [DW-1:0] p_wd   [N];
    int            m_ptr;
    logic [DW-1:0] m_rdata;

    function automatic logic [DW-1:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Reference winner: first requesting channel at or after the start point, wrapping.
    function automatic int pick(input logic [N-1:0] r, input int p, input bit rr);
        int s;
        s = rr ? p : 0;
        for (int k = 0; k < N; k++) begin
            if (r[(s + k) % N]) return (s + k) % N;
        end
        return -1;
    endfunction

    task automatic step();
        @(negedge clk);
    endtask

    task automatic apply_rr();
        if_rr.ch_req = req;
        for (int i = 0; i < N; i++) begin
            if_rr.ch_rw[i]               = p_rw[i];
            if_rr.ch_addr[i*AW +: AW]    = p_addr[i];
            if_rr.ch_wdata[i*DW +: DW]   = p_wd[i];
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step();
        step();
        total += 6;
        if (if_rr.mem_enable !== 1'b0) begin bad++; $display("FAIL reset_en: got %0b want 0", if_rr.mem_enable); end
        if (if_rr.ch_ack !== 3'b000)   begin bad++; $display("FAIL reset_ack: got %b want 000", if_rr.ch_ack); end
        if (gid_rr !== 2'd0)           begin bad++; $display("FAIL reset_gid: got %0d want 0", gid_rr); end
        if (busy_rr !== 1'b0)          begin bad++; $display("FAIL reset_busy: got %0b want 0", busy_rr); end
        if (to_rr !== 1'b0)            begin bad++; $display("FAIL reset_to: got %0b want 0", to_rr); end
        if (if_fx.ch_rdata !== '0)     begin bad++; $display("FAIL reset_rdata: got %h want 0", if_fx.ch_rdata); end
        reset   = 1'b1;
        m_ptr   = 0;
        m_rdata = '0;
    endtask

    // Random requesters and memory responder against a transaction-level model.
    task automatic run_rr(input int cycles, input bit hold_all, input int fixed_lat, input bit chk_order);
        int            phase;
        int            lat;
        int            win;
        bit            ack;
        bit            done;
        bit            e_en;
        bit            e_busy;
        logic [N-1:0]  e_ack;
        logic [DW-1:0] rd;
        int            order [$];
        int            exp_ord [4];
        exp_ord = '{0, 1, 2, 0};
        phase = 0; lat = 0; win = 0; done = 1'b0; e_en = 1'b0; e_busy = 1'b0;
        for (int n = 0; n < cycles + 200; n++) begin
            if (n >= cycles && phase == 0 && req == '0) begin
                done = 1'b1;
                break;
            end
            if (phase == 1) begin
                ack = (lat == 0);
                if (lat > 0) lat--;
            end else begin
                ack = ($urandom_range(0, 3) == 0);
            end
            rd = rand128();
            for (int i = 0; i < N; i++) begin
                if (!req[i] && n < cycles && (hold_all || $urandom_range(0, 2) == 0)) begin
                    req[i]    = 1'b1;
                    p_rw[i]   = 1'($urandom_range(0, 1));
                    p_addr[i] = $urandom;
                    p_wd[i]   = rand128();
                end
            end
            apply_rr();
            if_rr.mem_ack      = ack;
            if_rr.mem_data_out = rd;
            e_ack = '0;
            case (phase)
                0: begin
                    if (req != '0) begin
                        win    = pick(req, m_ptr, 1'b1);
                        phase  = 1;
                        lat    = (fixed_lat >= 0) ? fixed_lat : $urandom_range(0, 3);
                        e_en   = 1'b1;
                        e_busy = 1'b1;
                        order.push_back(win);
                    end else begin
                        e_en   = 1'b0;
                        e_busy = 1'b0;
                    end
                end
                1: begin
                    e_busy = 1'b1;
                    if (ack) begin
                        e_en  = 1'b0;
                        e_ack = N'(1) << win;
                        if (!p_rw[win]) m_rdata = rd;
                        m_ptr = (win + 1) % N;
                        phase = 2;
                    end else begin
                        e_en = 1'b1;
                    end
                end
                default: begin
                    e_en   = 1'b0;
                    e_busy = 1'b0;
                    phase  = 0;
                end
            endcase
            step();
            total += 5;
            if (if_rr.mem_enable !== e_en) begin bad++; $display("FAIL rr_en cyc %0d: got %0b want %0b", n, if_rr.mem_enable, e_en); end
            if (if_rr.ch_ack !== e_ack)    begin bad++; $display("FAIL rr_ack cyc %0d: got %b want %b", n, if_rr.ch_ack, e_ack); end
            if (busy_rr !== e_busy)        begin bad++; $display("FAIL rr_busy cyc %0d: got %0b want %0b", n, busy_rr, e_busy); end
            if (if_rr.ch_rdata !== m_rdata) begin bad++; $display("FAIL rr_rdata cyc %0d: got %h want %h", n, if_rr.ch_rdata, m_rdata); end
            if (to_rr !== 1'b0)            begin bad++; $display("FAIL rr_to cyc %0d: got %0b want 0", n, to_rr); end
            if (e_en) begin
                total += 4;
                if (gid_rr !== 2'(win))               begin bad++; $display("FAIL rr_gid cyc %0d: got %0d want %0d", n, gid_rr, win); end
                if (if_rr.mem_rw !== p_rw[win])       begin bad++; $display("FAIL rr_rw cyc %0d: got %0b want %0b", n, if_rr.mem_rw, p_rw[win]); end
                if (if_rr.mem_addr !== p_addr[win])   begin bad++; $display("FAIL rr_addr cyc %0d: got %h want %h", n, if_rr.mem_addr, p_addr[win]); end
                if (if_rr.mem_data_in !== p_wd[win])  begin bad++; $display("FAIL rr_wdata cyc %0d: got %h want %h", n, if_rr.mem_data_in, p_wd[win]); end
            end
            if (e_ack != '0) req[win] = 1'b0;
        end
        if_rr.mem_ack = 1'b0;
        total++;
        if (!done) begin bad++; $display("FAIL rr_drain: got busy want idle within budget"); end
        if (chk_order) begin
            total++;
            if (order.size() < 4) begin
                bad++; $display("FAIL rr_order_len: got %0d want >=4", order.size());
            end else begin
                for (int k = 0; k < 4; k++) begin
                    total++;
                    if (order[k] !== exp_ord[k]) begin bad++; $display("FAIL rr_order[%0d]: got %0d want %0d", k, order[k], exp_ord[k]); end
                end
            end
        end
    endtask

    task automatic test_rr_hold();
        run_rr(40, 1'b1, 2, 1'b1);
    endtask

    task automatic test_random();
        run_rr(400, 1'b0, -1, 1'b0);
    endtask

    task automatic test_single_read();
        logic [DW-1:0] aa;
        aa = {16{8'hAA}};
        p_rw[0] = 1'b0; p_addr[0] = 32'h40; req = 3'b001;
        apply_rr();
        step();
        total += 4;
        if (if_rr.mem_enable !== 1'b1)   begin bad++; $display("FAIL rd_en: got %0b want 1", if_rr.mem_enable); end
        if (if_rr.mem_rw !== 1'b0)       begin bad++; $display("FAIL rd_rw: got %0b want 0", if_rr.mem_rw); end
        if (if_rr.mem_addr !== 32'h40)   begin bad++; $display("FAIL rd_addr: got %h want 40", if_rr.mem_addr); end
        if (gid_rr !== 2'd0)             begin bad++; $display("FAIL rd_gid: got %0d want 0", gid_rr); end
        for (int c = 0; c < 3; c++) begin
            step();
            total += 2;
            if (if_rr.mem_enable !== 1'b1) begin bad++; $display("FAIL rd_hold_en %0d: got %0b want 1", c, if_rr.mem_enable); end
            if (if_rr.ch_ack !== 3'b000)   begin bad++; $display("FAIL rd_hold_ack %0d: got %b want 000", c, if_rr.ch_ack); end
        end
        if_rr.mem_ack = 1'b1; if_rr.mem_data_out = aa;
        step();
        if_rr.mem_ack = 1'b0; req = 3'b000; apply_rr();
        m_rdata = aa;
        total += 3;
        if (if_rr.ch_ack !== 3'b001)     begin bad++; $display("FAIL rd_ack: got %b want 001", if_rr.ch_ack); end
        if (if_rr.ch_rdata !== aa)       begin bad++; $display("FAIL rd_data: got %h want %h", if_rr.ch_rdata, aa); end
        if (if_rr.mem_enable !== 1'b0)   begin bad++; $display("FAIL rd_en_drop: got %0b want 0", if_rr.mem_enable); end
        step();
        total++;
        if (if_rr.ch_ack !== 3'b000)     begin bad++; $display("FAIL rd_release: got %b want 000", if_rr.ch_ack); end
        step();
    endtask

    task automatic test_write_drop();
        logic [DW-1:0] d;
        d = rand128();
        p_rw[2] = 1'b1; p_addr[2] = 32'h1234; p_wd[2] = d; req = 3'b100;
        apply_rr();
        step();
        req = 3'b000; p_addr[2] = $urandom; p_wd[2] = rand128(); apply_rr();
        for (int c = 0; c < 3; c++) begin
            total += 4;
            if (if_rr.mem_enable !== 1'b1)  begin bad++; $display("FAIL wr_en %0d: got %0b want 1", c, if_rr.mem_enable); end
            if (if_rr.mem_rw !== 1'b1)      begin bad++; $display("FAIL wr_rw %0d: got %0b want 1", c, if_rr.mem_rw); end
            if (if_rr.mem_addr !== 32'h1234) begin bad++; $display("FAIL wr_addr %0d: got %h want 1234", c, if_rr.mem_addr); end
            if (if_rr.mem_data_in !== d)    begin bad++; $display("FAIL wr_data %0d: got %h want %h", c, if_rr.mem_data_in, d); end
            step();
        end
        if_rr.mem_ack = 1'b1; if_rr.mem_data_out = rand128();
        step();
        if_rr.mem_ack = 1'b0;
        total += 2;
        if (if_rr.ch_ack !== 3'b100)     begin bad++; $display("FAIL wr_ack: got %b want 100", if_rr.ch_ack); end
        if (if_rr.ch_rdata !== m_rdata)  begin bad++; $display("FAIL wr_rdata: got %h want %h", if_rr.ch_rdata, m_rdata); end
        step();
        step();
    endtask

    task automatic test_fixed();
        if_fx.ch_req = 3'b101; if_fx.ch_rw = 3'b000;
        if_fx.ch_addr = {32'h300, 32'h200, 32'h100};
        for (int t = 0; t < 3; t++) begin
            step();
            total += 2;
            if (if_fx.mem_enable !== 1'b1) begin bad++; $display("FAIL fx_en %0d: got %0b want 1", t, if_fx.mem_enable); end
            if (gid_fx !== 2'd0)           begin bad++; $display("FAIL fx_gid %0d: got %0d want 0", t, gid_fx); end
            if_fx.mem_ack = 1'b1;
            step();
            if_fx.mem_ack = 1'b0;
            total++;
            if (if_fx.ch_ack !== 3'b001)   begin bad++; $display("FAIL fx_ack %0d: got %b want 001", t, if_fx.ch_ack); end
            if (t == 2) if_fx.ch_req = 3'b100;
            step();
        end
        step();
        total += 3;
        if (if_fx.mem_enable !== 1'b1)   begin bad++; $display("FAIL fx_en2: got %0b want 1", if_fx.mem_enable); end
        if (gid_fx !== 2'd2)             begin bad++; $display("FAIL fx_gid2: got %0d want 2", gid_fx); end
        if (if_fx.mem_addr !== 32'h300)  begin bad++; $display("FAIL fx_addr2: got %h want 300", if_fx.mem_addr); end
        if_fx.mem_ack = 1'b1;
        step();
        if_fx.mem_ack = 1'b0; if_fx.ch_req = 3'b000;
        total++;
        if (if_fx.ch_ack !== 3'b100)     begin bad++; $display("FAIL fx_ack2: got %b want 100", if_fx.ch_ack); end
        step();
        step();
    endtask

    task automatic test_timeout();
        logic [DW-1:0] rd;
        p_rw[1] = 1'b0; p_addr[1] = $urandom; req = 3'b010;
        apply_rr();
        step();
        total++;
        if (if_rr.mem_enable !== 1'b1) begin bad++; $display("FAIL to_en: got %0b want 1", if_rr.mem_enable); end
        for (int c = 1; c <= 11; c++) begin
            step();
            total += 2;
            if (to_rr !== (c >= 8))        begin bad++; $display("FAIL to_flag %0d: got %0b want %0b", c, to_rr, (c >= 8)); end
            if (if_rr.mem_enable !== 1'b1) begin bad++; $display("FAIL to_hold %0d: got %0b want 1", c, if_rr.mem_enable); end
        end
        rd = rand128();
        if_rr.mem_ack = 1'b1; if_rr.mem_data_out = rd;
        step();
        if_rr.mem_ack = 1'b0; req = 3'b000; apply_rr();
        total += 3;
        if (if_rr.ch_ack !== 3'b010)   begin bad++; $display("FAIL to_ack: got %b want 010", if_rr.ch_ack); end
        if (if_rr.ch_rdata !== rd)     begin bad++; $display("FAIL to_rdata: got %h want %h", if_rr.ch_rdata, rd); end
        if (to_rr !== 1'b1)            begin bad++; $display("FAIL to_sticky: got %0b want 1", to_rr); end
        step();
        step();
        total++;
        if (to_rr !== 1'b1)            begin bad++; $display("FAIL to_sticky2: got %0b want 1", to_rr); end
    endtask

    task automatic test_reset_mid();
        p_rw[0] = 1'b0; p_addr[0] = $urandom; req = 3'b001;
        apply_rr();
        step();
        step();
        total++;
        if (if_rr.mem_enable !== 1'b1) begin bad++; $display("FAIL rm_en: got %0b want 1", if_rr.mem_enable); end
        reset = 1'b0;
        step();
        reset = 1'b1; req = 3'b000; apply_rr();
        if_rr.mem_ack = 1'b1;
        total += 5;
        if (if_rr.mem_enable !== 1'b0) begin bad++; $display("FAIL rm_en0: got %0b want 0", if_rr.mem_enable); end
        if (if_rr.ch_ack !== 3'b000)   begin bad++; $display("FAIL rm_ack0: got %b want 000", if_rr.ch_ack); end
        if (gid_rr !== 2'd0)           begin bad++; $display("FAIL rm_gid: got %0d want 0", gid_rr); end
        if (to_rr !== 1'b0)            begin bad++; $display("FAIL rm_to: got %0b want 0", to_rr); end
        if (busy_rr !== 1'b0)          begin bad++; $display("FAIL rm_busy: got %0b want 0", busy_rr); end
        step();
        if_rr.mem_ack = 1'b0;
        for (int c = 0; c < 2; c++) begin
            total += 2;
            if (if_rr.ch_ack !== 3'b000)   begin bad++; $display("FAIL rm_late_ack %0d: got %b want 000", c, if_rr.ch_ack); end
            if (if_rr.mem_enable !== 1'b0) begin bad++; $display("FAIL rm_late_en %0d: got %0b want 0", c, if_rr.mem_enable); end
            step();
        end
    endtask

    initial begin
        total = 0; bad = 0;
        reset = 1'b0;
        req = '0;
        for (int i = 0; i < N; i++) begin
            p_rw[i] = 1'b0; p_addr[i] = '0; p_wd[i] = '0;
        end
        apply_rr();
        if_rr.mem_ack = 1'b0; if_rr.mem_data_out = '0;
        if_fx.ch_req = '0; if_fx.ch_rw = '0; if_fx.ch_addr = '0; if_fx.ch_wdata = '0;
        if_fx.mem_ack = 1'b0; if_fx.mem_data_out = '0;
        m_ptr = 0; m_rdata = '0;

        test_reset();
        test_rr_hold();
        test_random();
        test_single_read();
        test_write_drop();
        test_fixed();
        test_timeout();
        test_reset_mid();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish want finish before 500000");
        $fatal(1);
    end

endmodule
